// File: rtl/iter_divider_if.sv
// Request/result bundle for the iterative divider: the pipeline drives the
// request side (master), the divider drives status and result (slave).
interface iter_divider_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] f;
    logic [1:0]      dbg_state;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, f, dbg_state
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, f, dbg_state
    );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division on
// operand magnitudes, one quotient bit per cycle, sign fix-up at the end.
module iter_divider #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    iter_divider_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q;
    logic            qneg_q;
    logic            rneg_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] bmag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] f_q;

    logic            accept;
    logic            signed_op;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_f;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fin, r_fin, fix_f;

    // Handshake: a request is taken on any edge where start=1, flush=0 and the
    // unit is in IDLE or DONE; the result is valid on f in the single cycle
    // done=1 and is held until the next done. No other request is queued.
    always_comb begin
        accept    = (state_q == IDLE || state_q == DONE) && bus.start && !bus.flush;
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[XLEN-1];
        b_neg     = signed_op & bus.b[XLEN-1];
        a_abs     = a_neg ? -bus.a : bus.a;
        b_abs     = b_neg ? -bus.b : bus.b;
        div_zero  = (bus.b == '0);
        overflow  = signed_op && (bus.a == MIN_NEG) && (bus.b == ONES);
        special   = div_zero || overflow;
        special_f = '0;
        if (div_zero) begin
            special_f = bus.op[1] ? bus.a : ONES;
        end else if (overflow) begin
            special_f = bus.op[1] ? '0 : bus.a;
        end
    end

    // Trial subtraction on the shifted remainder; bit XLEN set means negative.
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, bmag_q};
        q_fin = qneg_q ? -quo_q : quo_q;
        r_fin = rneg_q ? -rem_q : rem_q;
        fix_f = op_q[1] ? r_fin : q_fin;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = special ? DONE : CALC;
            end
            CALC: begin
                if (bus.flush)          state_d = IDLE;
                else if (cnt_q == '0)   state_d = FIX;
            end
            FIX: begin
                state_d = bus.flush ? IDLE : DONE;
            end
            DONE: begin
                if (accept) state_d = special ? DONE : CALC;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            rem_q  <= '0;
            quo_q  <= '0;
            bmag_q <= '0;
            cnt_q  <= '0;
            f_q    <= '0;
        end else if (accept) begin
            op_q   <= bus.op;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            rem_q  <= '0;
            quo_q  <= a_abs;
            bmag_q <= b_abs;
            cnt_q  <= CNT_W'(XLEN - 1);
            if (special) f_q <= special_f;
        end else if (state_q == CALC) begin
            if (!trial[XLEN]) rem_q <= trial[XLEN-1:0];
            else              rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
            cnt_q <= cnt_q - CNT_W'(1);
        end else if (state_q == FIX && !bus.flush) begin
            f_q <= fix_f;
        end
    end

    assign bus.busy      = (state_q == CALC) || (state_q == FIX);
    assign bus.done      = (state_q == DONE);
    assign bus.f         = f_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: vector table, hand-built multi-cycle sequences and a
// random sweep, all results checked through an expected-value queue.
module tb_iter_divider;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;
    localparam logic [XLEN-1:0] ONES    = 32'hFFFF_FFFF;

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp_f;
        int              exp_lat;
    } vec_t;

    logic clk;
    logic rst_n;
    iter_divider_if #(.XLEN(XLEN)) bus();

    iter_divider #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [XLEN-1:0] exp_q[$];
    int  vec_cnt = 0;
    int  err_cnt = 0;
    bit  saw_done;
    bit  saw_busy;
    vec_t tbl[16];

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // One clock: sample outputs on the falling edge, score any done, then
    // return just after the next rising edge so inputs can be driven.
    task automatic step();
        logic [XLEN-1:0] e;
        @(negedge clk);
        saw_done = 1'b0;
        saw_busy = bus.busy;
        if (rst_n && bus.done) begin
            saw_done = 1'b1;
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL unexpected_done: got done=1 f=%h, required no done", bus.f);
            end else begin
                e = exp_q.pop_front();
                if (bus.f !== e) begin
                    err_cnt++;
                    $display("FAIL result: got f=%h, required %h", bus.f, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] e, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) exp_q.push_back(e);
        step();
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input string name, input int exp_lat, output int busy_n);
        int lat;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (saw_busy) busy_n++;
            if (saw_done) begin
                lat = i;
                break;
            end
        end
        check(name, 32'(lat), 32'(exp_lat));
    endtask

    function automatic logic [XLEN-1:0] ref_div(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            OP_DIV:  r = (b == 0) ? ONES : (a == MIN_NEG && b == ONES) ? a
                         : 32'($signed(a) / $signed(b));
            OP_DIVU: r = (b == 0) ? ONES : a / b;
            OP_REM:  r = (b == 0) ? a : (a == MIN_NEG && b == ONES) ? '0
                         : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    initial begin
        int busy_n;
        logic [1:0]      rop;
        logic [XLEN-1:0] ra, rb;
        int              rlat;

        tbl[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34};
        tbl[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          34};
        tbl[2]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        tbl[3]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        tbl[4]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        tbl[5]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
        tbl[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        tbl[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        tbl[8]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        tbl[9]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        tbl[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        tbl[11] = '{OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          34};
        tbl[12] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        tbl[13] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
        tbl[14] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};
        tbl[15] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) step();
        check("reset_busy",  32'(bus.busy), 32'd0);
        check("reset_done",  32'(bus.done), 32'd0);
        check("reset_f",     bus.f,         32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic latency and busy window on an ordinary unsigned divide.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
        wait_done("t1_latency", 34, busy_n);
        check("t1_busy_cycles", 32'(busy_n), 32'd33);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_f, 1'b1);
            wait_done($sformatf("tbl%0d_latency", i), tbl[i].exp_lat, busy_n);
        end

        // Flush together with a new start at +10: nothing completes, IDLE at +11.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (9) step();
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd50;
        bus.b     = 32'd5;
        step();
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_state", 32'(bus.dbg_state), 32'd0);
        check("flush_busy",  32'(bus.busy), 32'd0);
        issue(OP_DIV, 32'd9, 32'd3, 32'd3, 1'b1);
        wait_done("after_flush_latency", 34, busy_n);

        // Start held high while busy is ignored; the start in DONE is taken.
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        exp_q.push_back(32'd14);
        step();
        bus.a = 32'd1;
        bus.b = 32'd1;
        repeat (33) step();
        exp_q.push_back(32'd1);
        step();
        check("b2b_first_done", 32'(saw_done), 32'd1);
        bus.start = 1'b0;
        wait_done("b2b_second_latency", 34, busy_n);

        // Reset mid-operation clears outputs and cancels the pending result.
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (19) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy",  32'(bus.busy), 32'd0);
        check("midrst_done",  32'(bus.done), 32'd0);
        check("midrst_f",     bus.f,         32'd0);
        check("midrst_state", 32'(bus.dbg_state), 32'd0);
        repeat (40) step();

        // Random sweep against the reference model, biased toward corner operands.
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ra = MIN_NEG;
                1:       ra = 32'($urandom_range(0, 1000));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = ONES;
                2:       rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            rlat = (rb == 0 || (!rop[0] && ra == MIN_NEG && rb == ONES)) ? 1 : 34;
            issue(rop, ra, rb, ref_div(rop, ra, rb), 1'b1);
            wait_done($sformatf("rand%0d_latency", n), rlat, busy_n);
        end

        repeat (5) step();
        check("leftover_expected", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
